fx2_packet_reader: RTL and testbench
====================================

# fx2_packet_reader

Read-side master for the receive FIFO, running in the 48 MHz USB clock domain. When the FIFO signals a full packet and the FX2 endpoint has room, it drains exactly one packet of 16-bit words and presents them to the FX2 slave FIFO bus with write strobes. It is the synthesizable counterpart of the minimal FX2 emulation model used on the bench. It replaces that model between the FIFO's `packet_rdy`/`rd_req`/`dout` and the FX2 pins.

## Interface
- `PACKET_WORDS`, 256: words per USB packet (512 bytes); range 2..1024.
- `HOLDOFF`, 2: minimum cycles spent in IDLE after a packet, so the FIFO's `packet_rdy` can settle.
- `PKTEND_EN`, 0: 1 = pulse `pktend` after each packet.

- `clk` in 1: USB clock, 48 MHz; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserted (0) clears all state immediately.
- `bus_reset` in 1: synchronous, active-high soft clear.
- `enable` in 1: permits new packets to start; does not abort a packet in progress.
- `packet_rdy` in 1: FIFO holds at least `PACKET_WORDS` words.
- `rd_req` out 1: FIFO read request; the word is returned on `din` one cycle later.
- `din` in 16: FIFO read data.
- `ep_full` in 1: FX2 endpoint full flag, active-high.
- `fd` out 16: FX2 data bus, registered.
- `slwr` out 1: FX2 write strobe, active-high, registered; one word per high cycle.
- `pktend` out 1: one-cycle commit pulse.
- `busy` out 1: high in XFER or COMMIT.
- `pkt_count` out 16: packets completed, wraps modulo 2^16.

## Operation
- States:
  - IDLE: counters at 0; `idle_cnt` increments, saturating at `HOLDOFF`.
  - IDLE→XFER when `enable && packet_rdy && !ep_full && idle_cnt==HOLDOFF`.
  - XFER: issue reads, write words out. XFER→COMMIT on the edge that registers the `PACKET_WORDS`-th `slwr`.
  - COMMIT: exactly one cycle. `pktend`=`PKTEND_EN`, `pkt_count`+1, then →IDLE with `idle_cnt`=0.
- Counters:
  - `req_cnt` counts issued reads.
  - `wr_cnt` counts issued writes.
  - Both are 11 bits and are cleared on entry to XFER.
- `rd_req` = `state==XFER && req_cnt<PACKET_WORDS && !ep_full && !hold_valid && !rd_pend`. This is combinational.
- `rd_pend` is `rd_req` delayed one cycle. At most one read is ever in flight.
- Returned word, present when `rd_pend`=1:
  - If `!ep_full`: `fd<=din`, `slwr<=1`.
  - Otherwise: `hold<=din`, `hold_valid<=1`.
- When `hold_valid && !ep_full`: `fd<=hold`, `slwr<=1`, `hold_valid<=0`.
- `slwr` is 0 in every other cycle. `fd` retains its last value.
- The FIFO guarantees data once `packet_rdy` is seen, so no underrun path exists.
- `bus_reset` takes effect at the next edge:
  - state goes to IDLE;
  - `hold_valid`, `rd_pend`, `req_cnt`, `wr_cnt`, `pkt_count` go to 0;
  - the in-flight word is discarded.
- `enable` falling during XFER: the current packet completes, and no new packet starts.

## Timing
- Reset values: `rd_req`=0, `fd`=0, `slwr`=0, `pktend`=0, `busy`=0, `pkt_count`=0, state IDLE, `idle_cnt`=0.
- After reset, the first packet may therefore start only after `HOLDOFF` IDLE cycles.
- Latency: `rd_req` high in cycle t gives `din` valid in t+1 and `slwr` high in t+2 when `ep_full` stays low.
- Throughput: one read every 2 cycles, because of the one-in-flight rule. A packet with `ep_full` low takes 2·`PACKET_WORDS` cycles from entering XFER to the last `slwr`, plus 1 COMMIT cycle.
- Start: the first `rd_req` is in the same cycle state becomes XFER.
- `ep_full` rising in the cycle the word returns: the word goes to `hold`, and no `slwr` occurs until `ep_full` falls. `slwr` is then asserted on the next edge.
- `packet_rdy` is ignored outside IDLE.
- `ep_full` is ignored for starting a packet except in IDLE.

## Structure
- Package `fx2_reader_pkg`:
  - state enum (IDLE, XFER, COMMIT);
  - default `PACKET_WORDS`=256;
  - counter width 11.
- One sub-module, `fx2_skid`: a one-entry hold register with `load`, `take`, `valid`, `q`, owning `hold`/`hold_valid`.

## Test plan
- `ep_full`=0, `packet_rdy`=1, `PACKET_WORDS`=256, FIFO model returns 0..255:
  - required: 256 `slwr` pulses carrying `fd`=0..255 in order;
  - last `slwr` at cycle 512 after entering XFER;
  - `pkt_count`=1;
  - no `pktend` (`PKTEND_EN`=0).
- `ep_full` high for 5 cycles starting the cycle word 10 returns:
  - required: word 10 held, then written after `ep_full` falls;
  - no duplicate or lost word;
  - still exactly 256 strobes.
- `packet_rdy` held high continuously for 3 packets, `HOLDOFF`=2:
  - required: 3 packets;
  - each XFER entry at least 2 IDLE cycles after the previous COMMIT;
  - `pkt_count`=3.
- `bus_reset` at word 100:
  - required: next edge gives `slwr`=0, `busy`=0, `pkt_count`=0;
  - a new packet restarts from word 0 of the FIFO model.
- `reset` asserted mid-XFER, released asynchronously:
  - required: all outputs are at their reset values with no clock edge;
  - `PKTEND_EN`=1 run shows `pktend` exactly one cycle, one cycle after the last `slwr`.

Source files
------------

// File: rtl/fx2_reader_pkg.sv
// Shared types and sizing for the FX2 packet reader.
package fx2_reader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   localparam int DEFAULT_PACKET_WORDS = 256;

   // 11 bits hold counts up to 1024, the largest supported packet.
   localparam int CNT_W = 11;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fx2_skid.sv
// One-entry hold register. Parks a returned FIFO word while the FX2
// endpoint reports full. clr has priority over load, and load has
// priority over take.
module fx2_skid (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clr_i,
   input  logic        load_i,
   input  logic        take_i,
   input  logic [15:0] d_i,
   output logic        valid_o,
   output logic [15:0] q_o
);

   logic        hold_valid_q;
   logic [15:0] hold_q;

   // Capture a parked word, or release it once it has been written out.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else if (clr_i) begin
         hold_valid_q <= 1'b0;
      end else if (load_i) begin
         hold_q       <= d_i;
         hold_valid_q <= 1'b1;
      end else if (take_i) begin
         hold_valid_q <= 1'b0;
      end
   end

   assign valid_o = hold_valid_q;
   assign q_o     = hold_q;

endmodule

// File: rtl/fx2_packet_reader.sv
// Drains one packet at a time from the receive FIFO onto the FX2 slave
// FIFO bus. Only one FIFO read is in flight at a time, so the transfer
// rate is one word every two cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting; idle_cnt counts up to HOLDOFF before a new start
//   XFER   | issuing reads and writing words to the FX2 bus
//   COMMIT | single cycle after the last write; bumps pkt_count
module fx2_packet_reader
   import fx2_reader_pkg::*;
#(
   parameter int PACKET_WORDS = DEFAULT_PACKET_WORDS,  // 2..1024
   parameter int HOLDOFF      = 2,                     // 0..255
   parameter bit PKTEND_EN    = 1'b0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        bus_reset_i,
   input  logic        enable_i,
   input  logic        packet_rdy_i,
   output logic        rd_req_o,
   input  logic [15:0] din_i,
   input  logic        ep_full_i,
   output logic [15:0] fd_o,
   output logic        slwr_o,
   output logic        pktend_o,
   output logic        busy_o,
   output logic [15:0] pkt_count_o
);

   localparam cnt_t       PW_C    = cnt_t'(PACKET_WORDS);
   localparam cnt_t       PW_LAST = cnt_t'(PACKET_WORDS - 1);
   localparam logic [7:0] HOLD_C  = 8'(HOLDOFF);

   state_e      state_q, state_d;
   logic [7:0]  idle_cnt_q, idle_cnt_d;
   cnt_t        req_cnt_q, req_cnt_d;
   cnt_t        wr_cnt_q, wr_cnt_d;
   logic        rd_pend_q;
   logic [15:0] fd_q;
   logic        slwr_q;
   logic        pktend_q;
   logic [15:0] pkt_count_q;

   logic        rd_req;
   logic        busy;
   logic        start_xfer;
   logic        hold_valid;
   logic [15:0] hold_q;
   logic        hold_load;
   logic        wr_from_din;
   logic        wr_from_hold;
   logic        wr_now;
   logic        last_wr;

   assign start_xfer   = (state_q == IDLE) && enable_i && packet_rdy_i &&
                         !ep_full_i && (idle_cnt_q == HOLD_C);
   // A returning word goes straight out unless the endpoint is full.
   assign wr_from_din  = rd_pend_q && !ep_full_i;
   assign hold_load    = rd_pend_q && ep_full_i;
   assign wr_from_hold = hold_valid && !ep_full_i && !rd_pend_q;
   assign wr_now       = wr_from_din || wr_from_hold;
   assign last_wr      = wr_now && (wr_cnt_q == PW_LAST);

   fx2_skid u_skid (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (bus_reset_i),
      .load_i  (hold_load),
      .take_i  (wr_from_hold),
      .d_i     (din_i),
      .valid_o (hold_valid),
      .q_o     (hold_q)
   );

   // State register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; bus_reset overrides everything.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_xfer) state_d = XFER;
         XFER:    if (last_wr)    state_d = COMMIT;
         COMMIT:                  state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
      if (bus_reset_i) state_d = IDLE;
   end

   // FSM outputs; the first read issues in the first XFER cycle.
   always_comb begin
      rd_req = (state_q == XFER) && (req_cnt_q < PW_C) && !ep_full_i &&
               !hold_valid && !rd_pend_q;
      busy   = (state_q == XFER) || (state_q == COMMIT);
   end

   // Next values of the holdoff timer and the read/write counters.
   always_comb begin
      idle_cnt_d = '0;
      req_cnt_d  = req_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      if (state_q == IDLE && idle_cnt_q < HOLD_C) idle_cnt_d = idle_cnt_q + 8'd1;
      else if (state_q == IDLE)                   idle_cnt_d = idle_cnt_q;
      if (start_xfer) begin
         req_cnt_d = '0;
         wr_cnt_d  = '0;
      end else begin
         if (rd_req) req_cnt_d = req_cnt_q + cnt_t'(1);
         if (wr_now) wr_cnt_d  = wr_cnt_q + cnt_t'(1);
      end
      if (bus_reset_i) begin
         idle_cnt_d = '0;
         req_cnt_d  = '0;
         wr_cnt_d   = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         idle_cnt_q <= '0;
         req_cnt_q  <= '0;
         wr_cnt_q   <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         req_cnt_q  <= req_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // Registered FX2 bus outputs; the in-flight word is dropped on bus_reset.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rd_pend_q   <= 1'b0;
         fd_q        <= '0;
         slwr_q      <= 1'b0;
         pktend_q    <= 1'b0;
         pkt_count_q <= '0;
      end else if (bus_reset_i) begin
         rd_pend_q   <= 1'b0;
         slwr_q      <= 1'b0;
         pktend_q    <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         rd_pend_q <= rd_req;
         slwr_q    <= wr_now;
         pktend_q  <= (state_q == COMMIT) && PKTEND_EN;
         if (wr_from_din)       fd_q <= din_i;
         else if (wr_from_hold) fd_q <= hold_q;
         if (state_q == COMMIT) pkt_count_q <= pkt_count_q + 16'd1;
      end
   end

   assign rd_req_o    = rd_req;
   assign busy_o      = busy;
   assign fd_o        = fd_q;
   assign slwr_o      = slwr_q;
   assign pktend_o    = pktend_q;
   assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_fx2_packet_reader.sv
// Scoreboard bench for fx2_packet_reader. The main process drives the
// FIFO handshake and pushes expected words; the monitor pops one per slwr.
module tb_fx2_packet_reader;

   localparam int PW = 256;
   localparam int HO = 2;

   logic        clk = 1'b0;
   logic        reset, bus_reset, enable, packet_rdy, ep_full;
   logic [15:0] din;
   logic        rd_req, slwr, pktend, busy;
   logic [15:0] fd, pkt_count;
   logic        rd_req2, slwr2, pktend2, busy2;
   logic [15:0] fd2, pkt_count2;

   fx2_packet_reader #(.PACKET_WORDS(PW), .HOLDOFF(HO), .PKTEND_EN(1'b0)) dut (
      .clk_i(clk), .reset_i(reset), .bus_reset_i(bus_reset), .enable_i(enable),
      .packet_rdy_i(packet_rdy), .rd_req_o(rd_req), .din_i(din), .ep_full_i(ep_full),
      .fd_o(fd), .slwr_o(slwr), .pktend_o(pktend), .busy_o(busy), .pkt_count_o(pkt_count)
   );

   fx2_packet_reader #(.PACKET_WORDS(PW), .HOLDOFF(HO), .PKTEND_EN(1'b1)) dut_pe (
      .clk_i(clk), .reset_i(reset), .bus_reset_i(bus_reset), .enable_i(enable),
      .packet_rdy_i(packet_rdy), .rd_req_o(rd_req2), .din_i(din), .ep_full_i(ep_full),
      .fd_o(fd2), .slwr_o(slwr2), .pktend_o(pktend2), .busy_o(busy2), .pkt_count_o(pkt_count2)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int exp_q[$];
   int slwr_in_pkt = 0, last_slwr_cyc = 0, last_slwr2_cyc = -10;
   int xfer_start_cyc = 0, commit_cyc = -1, done_cnt = 0, last_len = 0;
   int w10_cyc = 0, pe1_cnt = 0, pe2_cnt = 0;
   bit busy_prev = 1'b0, aborting = 1'b0;
   logic [15:0] fifo_ptr;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_words(input int base);
      for (int i = 0; i < PW; i++) exp_q.push_back((base + i) & 16'hffff);
   endtask

   task automatic wait_done(input int n, input string name);
      int target = done_cnt + n;
      int k = 0;
      while (done_cnt < target && k < 4000) begin
         tick();
         k++;
      end
      chk(name, int'(done_cnt >= target), 1);
   endtask

   // FIFO model: data appears on din the cycle after rd_req.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_ptr <= '0;
         din      <= '0;
      end else if (bus_reset) begin
         fifo_ptr <= '0;
      end else if (rd_req) begin
         din      <= fifo_ptr;
         fifo_ptr <= fifo_ptr + 16'd1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: scoreboard pops, packet boundaries, pktend placement.
   always @(negedge clk) begin
      if (busy && !busy_prev) begin
         xfer_start_cyc = cyc;
         slwr_in_pkt = 0;
         if (commit_cyc >= 0) chk("idle_gap", int'(cyc - commit_cyc - 1 >= HO), 1);
      end
      if (slwr) begin
         if (exp_q.size() == 0) chk("slwr_unexpected", 1, 0);
         else chk("fd_word", int'(fd), exp_q.pop_front());
         if (slwr_in_pkt == 10) w10_cyc = cyc;
         slwr_in_pkt++;
         last_slwr_cyc = cyc;
      end
      if (slwr2) last_slwr2_cyc = cyc;
      if (pktend2) begin
         pe2_cnt++;
         chk("pktend_after_last_slwr", cyc - last_slwr2_cyc, 1);
      end
      if (pktend) pe1_cnt++;
      if (!busy && busy_prev) begin
         if (aborting) commit_cyc = -1;
         else begin
            commit_cyc = cyc - 1;
            done_cnt++;
            chk("strobes_per_pkt", slwr_in_pkt, PW);
            last_len = last_slwr_cyc - xfer_start_cyc;
         end
      end
      busy_prev = busy;
   end

   initial begin
      int k;
      int t;
      reset = 1'b0; bus_reset = 1'b0; enable = 1'b0; packet_rdy = 1'b0; ep_full = 1'b0;
      #2;
      chk("rst_rd_req", int'(rd_req), 0);
      chk("rst_fd", int'(fd), 0);
      chk("rst_slwr", int'(slwr), 0);
      chk("rst_pktend", int'(pktend), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pkt_count", int'(pkt_count), 0);
      #21 reset = 1'b1;
      tick();

      // Single packet, endpoint never full.
      push_words(0);
      enable = 1'b1; packet_rdy = 1'b1;
      wait_done(1, "pkt1_done");
      packet_rdy = 1'b0;
      chk("pkt1_last_slwr_cycle", last_len, 2 * PW);
      chk("pkt1_pkt_count", int'(pkt_count), 1);
      chk("pkt1_no_pktend", pe1_cnt, 0);
      repeat (5) tick();

      // Endpoint full for five cycles starting when word 10 returns.
      push_words(256);
      packet_rdy = 1'b1;
      k = 0;
      while (!(rd_req && fifo_ptr == 16'd266) && k < 200) begin tick(); k++; end
      chk("stall_reach_word10", int'(k < 200), 1);
      t = cyc;
      @(posedge clk); #1 ep_full = 1'b1;
      repeat (5) @(posedge clk);
      #1 ep_full = 1'b0;
      wait_done(1, "pkt2_done");
      packet_rdy = 1'b0;
      chk("stall_word10_cycle", w10_cyc, t + 7);
      chk("stall_last_slwr_cycle", last_len, 2 * PW + 5);
      chk("pkt2_pkt_count", int'(pkt_count), 2);
      repeat (5) tick();

      // Three back-to-back packets with packet_rdy held high.
      push_words(512); push_words(768); push_words(1024);
      packet_rdy = 1'b1;
      wait_done(3, "pkt3x_done");
      packet_rdy = 1'b0;
      chk("pkt3x_pkt_count", int'(pkt_count), 5);
      repeat (5) tick();

      // bus_reset after 100 words; the next packet restarts at FIFO word 0.
      push_words(1280);
      packet_rdy = 1'b1;
      k = 0;
      while (slwr_in_pkt < 100 && k < 400) begin tick(); k++; end
      chk("busrst_reach_word100", int'(k < 400), 1);
      aborting = 1'b1; bus_reset = 1'b1;
      tick();
      chk("busrst_slwr", int'(slwr), 0);
      chk("busrst_busy", int'(busy), 0);
      chk("busrst_pkt_count", int'(pkt_count), 0);
      bus_reset = 1'b0; aborting = 1'b0;
      exp_q.delete();
      push_words(0);
      wait_done(1, "busrst_restart_done");
      packet_rdy = 1'b0;
      chk("busrst_restart_pkt_count", int'(pkt_count), 1);
      repeat (5) tick();

      // Asynchronous reset in the middle of a transfer.
      push_words(256);
      packet_rdy = 1'b1;
      k = 0;
      while (slwr_in_pkt < 50 && k < 300) begin tick(); k++; end
      chk("arst_reach_word50", int'(k < 300), 1);
      @(posedge clk);
      #3 aborting = 1'b1; reset = 1'b0;
      #1;
      chk("arst_rd_req", int'(rd_req), 0);
      chk("arst_fd", int'(fd), 0);
      chk("arst_slwr", int'(slwr), 0);
      chk("arst_pktend", int'(pktend), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_pkt_count", int'(pkt_count), 0);
      #2 reset = 1'b1;
      exp_q.delete();
      aborting = 1'b0;
      push_words(0);
      wait_done(1, "arst_restart_done");
      packet_rdy = 1'b0;
      chk("arst_restart_pkt_count", int'(pkt_count), 1);
      repeat (5) tick();

      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_no_pktend", pe1_cnt, 0);
      chk("final_pktend_pulses", pe2_cnt, 7);
      chk("final_pe_pkt_count", int'(pkt_count2), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
